// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter with bounded lock in front of the data-side bridge.
// Each access is a one-cycle address phase followed by a one-cycle data phase.
module bus_arbiter #(
   parameter int LOCK_MAX = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_req,
   input  logic        m0_lock,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_byteen,
   output logic        m0_gnt,
   output logic        m0_ack,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_lock,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_byteen,
   output logic        m1_gnt,
   output logic        m1_ack,
   output logic [31:0] m1_rdata,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_byteen,
   input  logic [31:0] bus_rdata
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ADDR = 2'd1;
   localparam logic [1:0] DATA = 2'd2;

   logic [1:0]  state;
   logic        owner;
   logic        last;
   logic        held_lock;
   logic [3:0]  lock_cnt;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [3:0]  lat_byteen;

   logic prev_req;
   logic other_req;
   logic lock_active;
   logic winner;
   logic owner_lock;

   always_comb begin
      prev_req    = owner ? m1_req : m0_req;
      other_req   = owner ? m0_req : m1_req;
      owner_lock  = owner ? m1_lock : m0_lock;
      lock_active = held_lock && prev_req && (lock_cnt < 4'(LOCK_MAX));
      if (lock_active)
         winner = owner;
      else if (m0_req && m1_req)
         winner = ~last;
      else
         winner = m1_req;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last       <= 1'b1;
         held_lock  <= 1'b0;
         lock_cnt   <= '0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         lat_byteen <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (m0_req || m1_req) begin
                  state      <= ADDR;
                  owner      <= winner;
                  lat_addr   <= winner ? m1_addr   : m0_addr;
                  lat_wdata  <= winner ? m1_wdata  : m0_wdata;
                  lat_byteen <= winner ? m1_byteen : m0_byteen;
                  // lock_cnt only advances while the lock is actually starving the other master
                  if (winner != owner)
                     lock_cnt <= '0;
                  else if (lock_active && other_req)
                     lock_cnt <= lock_cnt + 4'd1;
               end
            end
            ADDR: state <= DATA;
            DATA: begin
               state     <= IDLE;
               last      <= owner;
               held_lock <= owner_lock;
               if (!owner_lock)
                  lock_cnt <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Address stays valid through DATA so the bridge read mux keeps selecting; byteen only in ADDR.
   assign bus_addr   = (state == IDLE) ? '0 : lat_addr;
   assign bus_wdata  = (state == IDLE) ? '0 : lat_wdata;
   assign bus_byteen = (state == ADDR) ? lat_byteen : '0;

   assign m0_gnt   = (state != IDLE) && !owner;
   assign m1_gnt   = (state != IDLE) && owner;
   assign m0_ack   = (state == DATA) && !owner;
   assign m1_ack   = (state == DATA) && owner;
   assign m0_rdata = m0_ack ? bus_rdata : '0;
   assign m1_rdata = m1_ack ? bus_rdata : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: drivers push expected accesses, a negedge monitor
// pops and compares on every ack and polices grant/idle/write-phase rules each cycle.
module tb_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m0_lock, m1_req, m1_lock;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [3:0]  m0_byteen, m1_byteen;
   logic        m0_gnt, m0_ack, m1_gnt, m1_ack;
   logic [31:0] m0_rdata, m1_rdata;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_byteen;

   bus_arbiter #(.LOCK_MAX(4)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_byteen(m0_byteen), .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_byteen(m1_byteen), .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_byteen(bus_byteen),
      .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  byteen;
      logic        lock;
   } txn_t;

   typedef struct {
      int          m;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  byteen;
      logic [31:0] rdata;
   } exp_t;

   txn_t m0_q[$];
   txn_t m1_q[$];
   exp_t sb[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int wr_seen = 0;
   int last_ack_cyc = -1;
   bit chk_space = 1'b0;
   int lat[2];

   function automatic logic [31:0] rd_model(input logic [31:0] a);
      return a ^ 32'h1234_5668;
   endfunction

   // Bridge model: read data only becomes valid in the cycle after the address phase.
   logic prev_gnt;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) prev_gnt <= 1'b0;
      else       prev_gnt <= m0_gnt | m1_gnt;
   end
   assign bus_rdata = prev_gnt ? rd_model(bus_addr) : 32'hBAD0_BAD0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input int m, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be, input logic [31:0] rd);
      exp_t e;
      e.m = m; e.addr = a; e.wdata = wd; e.byteen = be; e.rdata = rd;
      sb.push_back(e);
   endtask

   task automatic push_txn(input int m, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be, input logic lk);
      txn_t t;
      t.addr = a; t.wdata = wd; t.byteen = be; t.lock = lk;
      if (m == 0) m0_q.push_back(t);
      else        m1_q.push_back(t);
   endtask

   always @(negedge clk) begin
      int am;
      exp_t e;
      cyc++;
      if (!reset) begin
         chk("gnt_overlap", 32'(m0_gnt & m1_gnt), 32'd0);
         if (!m0_gnt && !m1_gnt) begin
            chk("idle_bus", bus_addr | bus_wdata | {28'd0, bus_byteen}, 32'd0);
            chk("idle_resp", m0_rdata | m1_rdata | {30'd0, m0_ack, m1_ack}, 32'd0);
         end else if (!m0_ack && !m1_ack) begin
            if (sb.size() == 0)
               chk("gnt_unexpected", {30'd0, m1_gnt, m0_gnt}, 32'd0);
            else begin
               chk("addr_gnt_master", 32'(m1_gnt), 32'(sb[0].m));
               chk("addr_phase_addr", bus_addr, sb[0].addr);
               chk("addr_phase_byteen", {28'd0, bus_byteen}, {28'd0, sb[0].byteen});
               chk("addr_phase_wdata", bus_wdata, sb[0].wdata);
               if (bus_byteen != 4'd0) wr_seen++;
            end
         end
         if (m0_ack || m1_ack) begin
            chk("ack_both", 32'(m0_ack & m1_ack), 32'd0);
            if (sb.size() == 0)
               chk("ack_unexpected", {30'd0, m1_ack, m0_ack}, 32'd0);
            else begin
               e  = sb.pop_front();
               am = m1_ack ? 1 : 0;
               chk("ack_master", 32'(am), 32'(e.m));
               chk("rdata", (am == 1) ? m1_rdata : m0_rdata, e.rdata);
               chk("rdata_nonowner", (am == 1) ? m0_rdata : m1_rdata, 32'd0);
               chk("data_addr", bus_addr, e.addr);
               chk("data_wdata", bus_wdata, e.wdata);
               chk("data_byteen", {28'd0, bus_byteen}, 32'd0);
               chk("data_gnt_owner", 32'((am == 1) ? m1_gnt : m0_gnt), 32'd1);
               chk("write_cycles", 32'(wr_seen), (e.byteen != 4'd0) ? 32'd1 : 32'd0);
               if (chk_space && last_ack_cyc >= 0)
                  chk("ack_spacing", 32'(cyc - last_ack_cyc), 32'd3);
               last_ack_cyc = cyc;
            end
            wr_seen = 0;
         end
      end
   end

   task automatic set_master(input int m, input logic rq, input txn_t t);
      if (m == 0) begin
         m0_req = rq; m0_lock = t.lock; m0_addr = t.addr; m0_wdata = t.wdata; m0_byteen = t.byteen;
      end else begin
         m1_req = rq; m1_lock = t.lock; m1_addr = t.addr; m1_wdata = t.wdata; m1_byteen = t.byteen;
      end
   endtask

   task automatic drive(input int m);
      txn_t t;
      txn_t z;
      bit   done;
      bit   got;
      int   n;
      z.addr = '0; z.wdata = '0; z.byteen = '0; z.lock = 1'b0;
      done = 1'b0;
      while (!done) begin
         if (m == 0 && m0_q.size() != 0)      begin t = m0_q.pop_front(); got = 1'b1; end
         else if (m == 1 && m1_q.size() != 0) begin t = m1_q.pop_front(); got = 1'b1; end
         else got = 1'b0;
         if (!got) done = 1'b1;
         else begin
            set_master(m, 1'b1, t);
            n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (!((m == 0) ? m0_ack : m1_ack) && n < 60);
            lat[m] = n;
            if (n >= 60) chk("ack_timeout", 32'((m == 0) ? m0_ack : m1_ack), 32'd1);
            @(posedge clk);
            #1;
         end
      end
      set_master(m, 1'b0, z);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      #1;
      chk("reset_gnt_ack", {28'd0, m0_gnt, m1_gnt, m0_ack, m1_ack}, 32'd0);
      chk("reset_bus", bus_addr | bus_wdata | {28'd0, bus_byteen}, 32'd0);
      chk("reset_rdata", m0_rdata | m1_rdata, 32'd0);
      sb.delete();
      wr_seen = 0;
      last_ack_cyc = -1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      m0_req = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0; m0_byteen = '0;
      m1_req = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0; m1_byteen = '0;
      @(posedge clk);
      #1;
      apply_reset();

      // single read by M0
      push_exp(0, 32'h0000_0010, 32'h0, 4'h0, 32'h1234_5678);
      push_txn(0, 32'h0000_0010, 32'h0, 4'h0, 1'b0);
      drive(0);
      chk("read_latency", 32'(lat[0]), 32'd3);
      repeat (2) @(posedge clk);
      #1;

      // write to TC0 by M1
      push_exp(1, 32'h0000_7F04, 32'hA5A5_0001, 4'hF, 32'h1234_296C);
      push_txn(1, 32'h0000_7F04, 32'hA5A5_0001, 4'hF, 1'b0);
      drive(1);
      chk("write_latency", 32'(lat[1]), 32'd3);
      repeat (2) @(posedge clk);
      #1;

      // simultaneous requests after reset: M0, M1, M0, M1
      apply_reset();
      chk_space = 1'b1;
      push_exp(0, 32'h100, 32'h0, 4'h0, rd_model(32'h100));
      push_exp(1, 32'h104, 32'h11, 4'h3, rd_model(32'h104));
      push_exp(0, 32'h108, 32'h22, 4'hC, rd_model(32'h108));
      push_exp(1, 32'h10C, 32'h0, 4'h0, rd_model(32'h10C));
      push_txn(0, 32'h100, 32'h0, 4'h0, 1'b0);
      push_txn(0, 32'h108, 32'h22, 4'hC, 1'b0);
      push_txn(1, 32'h104, 32'h11, 4'h3, 1'b0);
      push_txn(1, 32'h10C, 32'h0, 4'h0, 1'b0);
      fork
         drive(0);
         drive(1);
      join
      repeat (2) @(posedge clk);
      #1;

      // lock: M1 gets 1 round-robin + 4 locked grants, then M0; then M1 drops lock
      apply_reset();
      begin
         int          ord[11];
         logic [31:0] a;
         int          k0;
         int          k1;
         ord = '{0, 1, 1, 1, 1, 1, 0, 1, 0, 1, 0};
         k0 = 0;
         k1 = 0;
         for (int i = 0; i < 11; i++) begin
            if (ord[i] == 0) begin
               a = 32'h200 + 32'(4 * k0);
               push_txn(0, a, 32'h0, 4'h0, 1'b0);
               k0++;
            end else begin
               a = 32'h300 + 32'(4 * k1);
               push_txn(1, a, 32'h0, 4'h0, (k1 < 5) ? 1'b1 : 1'b0);
               k1++;
            end
            push_exp(ord[i], a, 32'h0, 4'h0, rd_model(a));
         end
      end
      fork
         drive(0);
         drive(1);
      join
      chk_space = 1'b0;
      chk("lock_sb_drained", 32'(sb.size()), 32'd0);
      repeat (2) @(posedge clk);
      #1;

      // reset in the ADDR phase of an M0 write
      apply_reset();
      push_exp(0, 32'h0000_7F00, 32'hDEAD_0001, 4'hF, 32'h0);
      m0_req = 1'b1; m0_addr = 32'h0000_7F00; m0_wdata = 32'hDEAD_0001; m0_byteen = 4'hF;
      @(posedge clk);
      #2;
      chk("pre_reset_gnt", 32'(m0_gnt), 32'd1);
      chk("pre_reset_byteen", {28'd0, bus_byteen}, 32'hF);
      m0_req = 1'b0; m0_addr = '0; m0_wdata = '0; m0_byteen = '0;
      apply_reset();
      push_exp(1, 32'h0000_7F10, 32'h0, 4'h0, rd_model(32'h0000_7F10));
      push_txn(1, 32'h0000_7F10, 32'h0, 4'h0, 1'b0);
      drive(1);
      chk("post_reset_latency", 32'(lat[1]), 32'd3);
      repeat (2) @(posedge clk);
      #1;

      // read of TC1 with bus data only valid in DATA
      push_exp(0, 32'h0000_7F18, 32'h0, 4'h0, 32'h1234_2970);
      push_txn(0, 32'h0000_7F18, 32'h0, 4'h0, 1'b0);
      drive(0);
      repeat (3) @(posedge clk);
      #1;
      chk("final_sb_drained", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL global_timeout actual=running required=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Two-master arbiter in front of the data-side system bridge. Shares the single bridge port (DM, TC0 at 0x7F00-0x7F0B, TC1 at 0x7F10-0x7F1B, interrupt generator at 0x7F20) between the CPU data port (M0) and a DMA/debug master (M1). Sequences each access as an address phase followed by a data phase. Uses round-robin priority with a bounded lock for atomic multi-access sequences.

Parameters:
LOCK_MAX, 4, max consecutive locked grants to one master while the other is requesting (legal 1..15)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
m0_req  in  1  M0 access request, held until m0_ack
m0_lock  in  1  M0 asks to retain the bus for its next access
m0_addr  in  32  M0 byte address
m0_wdata  in  32  M0 write data
m0_byteen  in  4  M0 byte enables, 0 = read
m0_gnt  out  1  M0 owns bus (ADDR and DATA phases)
m0_ack  out  1  one-cycle completion strobe for M0
m0_rdata  out  32  read data to M0, valid when m0_ack
m1_req, m1_lock, m1_addr, m1_wdata, m1_byteen, m1_gnt, m1_ack, m1_rdata  same as M0, for M1
bus_addr  out  32  to bridge m_tmp_data_addr
bus_wdata  out  32  to bridge m_tmp_data_wdata
bus_byteen  out  4  to bridge m_tmp_data_byteen
bus_rdata  in  32  from bridge m_tmp_data_rdata

Behaviour:
- States: IDLE, ADDR, DATA. Register owner (0/1), last (last-granted master), lock_cnt (4 bit), and latched addr/wdata/byteen.
- Reset (async): state=IDLE, owner=0, last=1 (M0 wins the first tie), lock_cnt=0. All outputs 0.
- IDLE: no req -> stay in IDLE. Otherwise pick winner, latch its addr/wdata/byteen, set owner, then -> ADDR.
- Winner selection:
  - Only one requester: that requester wins.
  - Both requesting, lock inactive: the master != last wins.
  - Lock active: previous owner held lock at its ack, still requests, and lock_cnt < LOCK_MAX. The previous owner wins regardless of last.
- ADDR (1 cycle): bus_addr/bus_wdata/bus_byteen = latched values; gnt of owner = 1. Writes occur at the edge ending ADDR. Next state is DATA.
- DATA (1 cycle):
  - bus_addr stays = latched addr, so the bridge read mux and TC Dout select stay valid. bus_byteen = 0, so there is no double write. bus_wdata = latched value.
  - Owner's ack = 1 and owner's rdata = bus_rdata (combinational pass-through). Non-owner rdata = 0.
  - last <= owner; record lock_x of owner. Next state is IDLE.
- lock_cnt: increments when a lock-active grant is made while the other master requests; clears on any grant to a different master or when the owner drops lock. At LOCK_MAX, round-robin applies.
- Latency: req seen in IDLE cycle N -> gnt in N+1, N+2; ack in N+2. Minimum 3 cycles per access, one access per 3 cycles.
- Request fields are sampled only at the IDLE->ADDR edge. Changes afterwards are ignored. req during ADDR/DATA is not re-evaluated until the next IDLE.
- Idle bus: bus_addr=0, bus_wdata=0, bus_byteen=0, all gnt/ack=0, all rdata=0.
- Reset mid-access: immediate return to IDLE, no ack issued, and bus_byteen forced to 0 asynchronously. A write is lost unless its ADDR edge has already occurred.
- Never two gnt high in the same cycle; ack only to the current owner.

Test Plan:
- Single read: M0 req, addr 0x0000_0010, byteen 0, bus_rdata 0x1234_5678 -> m0_gnt cycles 1-2, m0_ack cycle 2 with m0_rdata 0x1234_5678. bus_byteen stays 0.
- Write to TC0: M1 req, addr 0x7F04, wdata 0xA5A5_0001, byteen 4'hF -> bus_byteen 4'hF for exactly one cycle (ADDR), 0 in DATA, m1_ack one cycle later.
- Simultaneous req after reset, both held for 4 accesses -> grant order M0, M1, M0, M1. Acks 3 cycles apart. gnt never overlaps.
- Lock: M1 lock=1, both requesting continuously, LOCK_MAX=4 -> M1 wins 1 round-robin + 4 locked grants, then M0 is granted. M1 drops lock -> strict alternation resumes.
- Reset during ADDR of an M0 write -> all outputs 0 at once, no m0_ack. After release, an M1 request is granted normally with last=1 behaviour.
- Read of TC1 0x7F18 with bus_rdata changing only in DATA -> bus_addr held 0x7F18 in both ADDR and DATA. m0_rdata equals the DATA-cycle bus_rdata.
